ir_prefetch_queue: RTL

//   Parametrised instruction register with a small prefetch FIFO between fetch and decode.

---
 rtl/ir_prefetch_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/ir_prefetch_queue.sv
// Instruction register fronted by a small prefetch FIFO between fetch and decode.
// The head word is presented to decode split into opcode (MSBs) and operand (LSBs).
module ir_prefetch_queue #(
  parameter  int INSTR_W   = 8,
  parameter  int OPCODE_W  = 3,
  parameter  int DEPTH     = 4,
  localparam int OPERAND_W = INSTR_W - OPCODE_W,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [INSTR_W-1:0]   in_data,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic [OPERAND_W-1:0] out_operand,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (OPCODE_W >= INSTR_W)) begin : g_bad_params
    $error("ir_prefetch_queue: DEPTH must be a power of 2 >= 2 and OPCODE_W < INSTR_W");
  end

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [INSTR_W-1:0] head;

  // Handshake flags derive only from count_q, so no input reaches an output combinationally.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stale storage is masked whenever the queue is empty.
  assign head        = mem_q[rd_ptr_q];
  assign out_opcode  = out_valid ? head[INSTR_W-1 -: OPCODE_W] : '0;
  assign out_operand = out_valid ? head[OPERAND_W-1:0] : '0;

endmodule
